// File: rtl/period_stb_gen_if.sv
// Reference input, control/config inputs and strobe/status outputs of period_stb_gen.
// The master drives sig/start/stop/phase/width; the slave (the generator) drives the rest.
interface period_stb_gen_if #(
    parameter int CNT_W = 32
);
    logic             sig_i;
    logic             start_i;
    logic             stop_i;
    logic [CNT_W-1:0] phase_i;
    logic [CNT_W-1:0] width_i;
    logic             stb_o;
    logic [CNT_W-1:0] period_o;
    logic             rdy_o;
    logic             busy_o;
    logic             err_o;

    modport master (
        output sig_i, start_i, stop_i, phase_i, width_i,
        input  stb_o, period_o, rdy_o, busy_o, err_o
    );

    modport slave (
        input  sig_i, start_i, stop_i, phase_i, width_i,
        output stb_o, period_o, rdy_o, busy_o, err_o
    );
endinterface

// File: rtl/period_stb_gen.sv
// Measures the averaged period of sig_i, then free-runs a phase-offset strobe at that period.
// Optional macro PERIOD_STB_GEN_TIMEOUT_EN adds an edge timeout in SYNC/MEASURE.
module period_stb_gen #(
    parameter int CNT_W       = 32,
    parameter int AVG_LOG2    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 2**20
) (
    input  logic            clk_i,
    input  logic            arst_i,
    period_stb_gen_if.slave bus
);
    localparam int                ACC_W     = CNT_W + AVG_LOG2;
    localparam int                EDGE_W    = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0]  IVL_MAX   = '1;
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [5:0] {
        IDLE    = 6'b000001,
        SYNC    = 6'b000010,
        MEASURE = 6'b000100,
        CALC    = 6'b001000,
        RUN     = 6'b010000,
        ERR     = 6'b100000
    } state_t;

    state_t             state_reg, state_next;
    logic [SYNC_STAGES-1:0] sync_reg, sync_next;
    logic               sig_d_reg, sig_pe_reg;
    logic [CNT_W-1:0]   ivl_reg, period_reg, phase_reg, width_reg, ph_reg;
    logic [EDGE_W-1:0]  edge_cnt_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic               stb_reg;
    logic [CNT_W-1:0]   calc_period;
    logic               calc_bad;
    logic               timeout_hit;
    logic [CNT_W-1:0]   win_ph, win_phase, win_width;
    logic [CNT_W:0]     win_end;
    logic               in_win;

    assign sync_next[0] = bus.sig_i;
    genvar gi;
    generate
        for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            assign sync_next[gi] = sync_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            sync_reg   <= '0;
            sig_d_reg  <= 1'b0;
            sig_pe_reg <= 1'b0;
        end else begin
            sync_reg   <= sync_next;
            sig_d_reg  <= sync_reg[SYNC_STAGES-1];
            sig_pe_reg <= sync_reg[SYNC_STAGES-1] & ~sig_d_reg;
        end
    end

    assign calc_period = acc_reg[ACC_W-1:AVG_LOG2];
    assign calc_bad    = (calc_period < CNT_W'(2)) ||
                         (({1'b0, bus.phase_i} + {1'b0, bus.width_i}) > {1'b0, calc_period});

`ifdef PERIOD_STB_GEN_TIMEOUT_EN
    logic [CNT_W-1:0] tmo_reg;
    logic             waiting;
    assign waiting     = (state_reg == SYNC) || (state_reg == MEASURE);
    assign timeout_hit = waiting && !sig_pe_reg && (tmo_reg == CNT_W'(TIMEOUT - 1));

    // Restarts at 0 on every edge and on every fresh entry into SYNC.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i)
            tmo_reg <= '0;
        else if (sig_pe_reg || !(state_next == SYNC || state_next == MEASURE) ||
                 (state_next == SYNC && state_reg != SYNC))
            tmo_reg <= '0;
        else
            tmo_reg <= tmo_reg + CNT_W'(1);
    end
`else
    localparam int unused_timeout = TIMEOUT;
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = IDLE;
            SYNC:    if (timeout_hit) state_next = ERR;
                     else if (sig_pe_reg) state_next = MEASURE;
            MEASURE: if (ivl_reg == IVL_MAX || timeout_hit) state_next = ERR;
                     else if (sig_pe_reg && edge_cnt_reg == EDGE_LAST) state_next = CALC;
            CALC:    state_next = calc_bad ? ERR : RUN;
            RUN:     state_next = RUN;
            ERR:     state_next = ERR;
            default: state_next = IDLE;
        endcase
        if (bus.start_i) state_next = SYNC;
        if (bus.stop_i)  state_next = IDLE;
    end

    always_comb begin
        bus.rdy_o  = (state_reg == RUN);
        bus.busy_o = (state_reg == SYNC) || (state_reg == MEASURE) || (state_reg == CALC);
        bus.err_o  = (state_reg == ERR);
    end

    // CALC counts as phase 0 so a phase-0 strobe is already high in the first RUN cycle.
    always_comb begin
        win_ph    = ph_reg;
        win_phase = phase_reg;
        win_width = width_reg;
        if (state_reg == CALC) begin
            win_ph    = '0;
            win_phase = bus.phase_i;
            win_width = bus.width_i;
        end
    end
    assign win_end = {1'b0, win_phase} + {1'b0, win_width};
    assign in_win  = (win_ph >= win_phase) && ({1'b0, win_ph} < win_end);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            ivl_reg      <= '0;
            edge_cnt_reg <= '0;
            acc_reg      <= '0;
            period_reg   <= '0;
            phase_reg    <= '0;
            width_reg    <= '0;
            ph_reg       <= '0;
            stb_reg      <= 1'b0;
        end else begin
            if (state_next == SYNC || state_reg == SYNC) begin
                ivl_reg      <= '0;
                edge_cnt_reg <= '0;
                acc_reg      <= '0;
            end else if (state_reg == MEASURE) begin
                if (sig_pe_reg) begin
                    acc_reg      <= acc_reg + ACC_W'(ivl_reg) + ACC_W'(1);
                    ivl_reg      <= '0;
                    edge_cnt_reg <= edge_cnt_reg + EDGE_W'(1);
                end else if (ivl_reg != IVL_MAX) begin
                    ivl_reg <= ivl_reg + CNT_W'(1);
                end
            end
            if (state_reg == CALC) begin
                period_reg <= calc_period;
                phase_reg  <= bus.phase_i;
                width_reg  <= bus.width_i;
                ph_reg     <= CNT_W'(1);
            end else if (state_reg == RUN) begin
                ph_reg <= (ph_reg == period_reg - CNT_W'(1)) ? '0 : ph_reg + CNT_W'(1);
            end
            stb_reg <= in_win && (state_next == RUN);
        end
    end

    assign bus.stb_o    = stb_reg;
    assign bus.period_o = period_reg;
endmodule

// File: tb/tb_period_stb_gen.sv
// Scoreboard bench for period_stb_gen: the stimulus side predicts each measurement result,
// a negedge monitor pops predictions when the block finishes measuring and tracks the strobe.
module tb_period_stb_gen;
    localparam int CNT_W    = 16;
    localparam int AVG_LOG2 = 2;
    localparam int TMO      = 100;

    typedef struct {
        bit err;
        int period;
        int phase;
        int width;
    } exp_t;

    logic clk  = 1'b0;
    logic arst = 1'b1;
    always #5 clk = ~clk;

    period_stb_gen_if #(.CNT_W(CNT_W)) bus ();

    period_stb_gen #(
        .CNT_W(CNT_W), .AVG_LOG2(AVG_LOG2), .SYNC_STAGES(2), .TIMEOUT(TMO)
    ) dut (
        .clk_i (clk),
        .arst_i(arst),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   model_period = 0;

    task automatic check(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Strobe is high when the cycle count since the anchor, modulo the period, lies in the window.
    function automatic bit in_win(input int x, input exp_t e);
        return (x >= e.phase) && (x < e.phase + e.width);
    endfunction

    // Monitor: j counts cycles from the first RUN cycle (anchor + 1), so stb at j = window(j mod P).
    bit   prev_busy = 0;
    bit   have_cur  = 0;
    exp_t cur;
    int   j = 0;
    always @(negedge clk) begin
        if (arst) begin
            exp_q.delete();
            have_cur  = 0;
            prev_busy = 0;
            check("stb_in_reset", bus.stb_o, 0);
        end else begin
            if (prev_busy && !bus.busy_o && (bus.rdy_o || bus.err_o)) begin
                check("result_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    have_cur = 1;
                    j = 0;
                    check("result_err", bus.err_o, cur.err);
                    check("result_rdy", bus.rdy_o, !cur.err);
                    check("result_period", bus.period_o, cur.period);
                    $display("TXN period=%0d phase=%0d width=%0d err=%0d -> period_o=%0d rdy=%0d err_o=%0d",
                             cur.period, cur.phase, cur.width, cur.err, bus.period_o, bus.rdy_o, bus.err_o);
                end
            end
            if (bus.rdy_o) begin
                if (have_cur && cur.period > 0) begin
                    check("stb_run", bus.stb_o, in_win(j % cur.period, cur));
                    j++;
                end else begin
                    check("rdy_unexpected", bus.rdy_o, 0);
                end
            end else begin
                have_cur = 0;
                check("stb_not_running", bus.stb_o, 0);
            end
            prev_busy = bus.busy_o;
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        bus.start_i = 1'b1;
        cyc();
        bus.start_i = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop_i = 1'b1;
        cyc();
        bus.stop_i = 1'b0;
    endtask

    // Start a measurement, feed a first edge plus four intervals, and predict the outcome.
    task automatic measure(input int d0, input int d1, input int d2, input int d3,
                           input int ph, input int wd);
        int   d[4];
        int   waited;
        exp_t e;
        d = '{d0, d1, d2, d3};
        bus.phase_i = CNT_W'(ph);
        bus.width_i = CNT_W'(wd);
        bus.sig_i   = 1'b0;
        pulse_start();
        cyc(3);
        check("busy_measuring", bus.busy_o, 1);
        e.period = (d0 + d1 + d2 + d3) / (1 << AVG_LOG2);
        e.phase  = ph;
        e.width  = wd;
        e.err    = (e.period < 2) || (ph + wd > e.period);
        model_period = e.period;
        exp_q.push_back(e);
        for (int k = 0; k < 5; k++) begin
            bus.sig_i = 1'b1;
            cyc(2);
            bus.sig_i = 1'b0;
            if (k < 4) cyc(d[k] - 2);
        end
        waited = 0;
        while (bus.busy_o && waited < 20) begin
            cyc();
            waited++;
        end
        check("measure_done", bus.busy_o, 0);
        @(negedge clk);
        #1;
        check("result_seen", exp_q.size(), 0);
        bus.phase_i = CNT_W'($urandom);
        bus.width_i = CNT_W'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   n;
        bit   all_busy;
        int   r[4];
        int   p;
        int   ph;
        int   wd;
        exp_t e;

        bus.sig_i   = 1'b0;
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
        bus.phase_i = '0;
        bus.width_i = '0;

        cyc(3);
        check("reset_stb", bus.stb_o, 0);
        check("reset_rdy", bus.rdy_o, 0);
        check("reset_busy", bus.busy_o, 0);
        check("reset_err", bus.err_o, 0);
        check("reset_period", bus.period_o, 0);
        arst = 1'b0;
        cyc(3);
        check("idle_busy", bus.busy_o, 0);
        check("idle_rdy", bus.rdy_o, 0);

        measure(10, 10, 10, 10, 3, 2);
        cyc(35);
        measure(10, 10, 10, 11, 0, 4);
        cyc(25);
        measure(9, 11, 10, 10, 6, 4);
        cyc(25);

        measure(10, 10, 10, 10, 8, 3);
        cyc(5);
        check("err_held", bus.err_o, 1);
        pulse_start();
        check("err_cleared", bus.err_o, 0);
        check("err_restart_busy", bus.busy_o, 1);
        pulse_stop();
        check("stop_to_idle", bus.busy_o, 0);

        bus.sig_i = 1'b0;
`ifdef PERIOD_STB_GEN_TIMEOUT_EN
        e.err = 1; e.period = model_period; e.phase = 0; e.width = 0;
        exp_q.push_back(e);
        pulse_start();
        check("timeout_sync_busy", bus.busy_o, 1);
        n = 0;
        while (!bus.err_o && n < 200) begin
            cyc();
            n++;
        end
        check("timeout_cycles", n, TMO);
        pulse_stop();
`else
        pulse_start();
        all_busy = 1;
        for (int k = 0; k < 150; k++) begin
            cyc();
            if (!bus.busy_o) all_busy = 0;
        end
        check("no_timeout_busy", all_busy, 1);
        pulse_stop();
`endif

        measure(12, 12, 12, 12, 2, 5);
        cyc(15);
        bus.start_i = 1'b1;
        bus.stop_i  = 1'b1;
        cyc();
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
        check("stop_wins_rdy", bus.rdy_o, 0);
        check("stop_wins_stb", bus.stb_o, 0);
        check("stop_wins_busy", bus.busy_o, 0);

        measure(10, 10, 10, 10, 3, 2);
        n = 0;
        while (!bus.stb_o && n < 30) begin
            cyc();
            n++;
        end
        check("stb_before_reset", bus.stb_o, 1);
        #2;
        arst = 1'b1;
        #1;
        check("arst_stb", bus.stb_o, 0);
        check("arst_rdy", bus.rdy_o, 0);
        check("arst_busy", bus.busy_o, 0);
        check("arst_err", bus.err_o, 0);
        check("arst_period", bus.period_o, 0);
        model_period = 0;
        cyc(3);
        arst = 1'b0;
        cyc(30);
        check("post_reset_rdy", bus.rdy_o, 0);
        check("post_reset_period", bus.period_o, model_period);

        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < 4; k++) r[k] = $urandom_range(3, 24);
            p  = (r[0] + r[1] + r[2] + r[3]) / 4;
            ph = $urandom_range(0, p);
            wd = $urandom_range(0, p - ph + 2);
            measure(r[0], r[1], r[2], r[3], ph, wd);
            cyc(2 * p + 3);
            if ($urandom_range(0, 1) == 1) pulse_stop();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
